inv_mix_col_seq: RTL

- Sequential AES InvMixColumns unit for the decryption datapath. It is the inverse of the existing combinational MixColumns stage.
- Accepts one 128-bit state via valid/ready and processes LANES 32-bit columns per clock through shared GF(2^8) multiply-by-{9,11,13,14} logic.
- Presents the 128-bit result on a valid/ready output port.
- Sits between InvShiftRows/InvSubBytes and AddRoundKey in the iterative decryption round.

---
 rtl/inv_mix_col_seq.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/inv_mix_col_seq.sv
// Sequential AES InvMixColumns: LANES columns per clock over shared xtime logic.
// Optional forward MixColumns select when INV_MIX_COL_FWD_EN is defined.
module inv_mix_col_seq #(
  parameter int unsigned LANES = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
`ifdef INV_MIX_COL_FWD_EN
  input  logic         fwd,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  localparam int unsigned NCYC = (LANES == 0) ? 1 : 4 / LANES;
  localparam int unsigned CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
    $error("inv_mix_col_seq: LANES must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic            last;
  logic [127:0]    work;
  logic [127:0]    res;
  logic            sel_fwd;
  logic [31:0]     grp_in  [LANES];
  logic [31:0]     grp_out [LANES];

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One xtime chain per byte feeds both directions; m_a..m_d are the
  // diagonal, +1, +2 and +3 circulant coefficients applied to each byte.
  function automatic logic [31:0] col_mix(input logic [31:0] x, input logic f);
    logic [7:0]  b1 [4];
    logic [7:0]  b2 [4];
    logic [7:0]  b4 [4];
    logic [7:0]  b8 [4];
    logic [7:0]  m_a [4];
    logic [7:0]  m_b [4];
    logic [7:0]  m_c [4];
    logic [7:0]  m_d [4];
    logic [31:0] y;
    y = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      b1[r] = x[8*r +: 8];
      b2[r] = xt(b1[r]);
      b4[r] = xt(b2[r]);
      b8[r] = xt(b4[r]);
      if (f) begin
        m_a[r] = b2[r];
        m_b[r] = b2[r] ^ b1[r];
        m_c[r] = b1[r];
        m_d[r] = b1[r];
      end else begin
        m_a[r] = b8[r] ^ b4[r] ^ b2[r];
        m_b[r] = b8[r] ^ b2[r] ^ b1[r];
        m_c[r] = b8[r] ^ b4[r] ^ b1[r];
        m_d[r] = b8[r] ^ b1[r];
      end
    end
    for (int unsigned r = 0; r < 4; r++) begin
      y[8*r +: 8] = m_a[r] ^ m_b[(r + 1) % 4] ^ m_c[(r + 2) % 4] ^ m_d[(r + 3) % 4];
    end
    return y;
  endfunction

`ifdef INV_MIX_COL_FWD_EN
  logic fwd_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_q <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      fwd_q <= fwd;
    end
  end

  assign sel_fwd = fwd_q;
`else
  assign sel_fwd = 1'b0;
`endif

  assign last = (cnt == CW'(NCYC - 1));

  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      grp_in[l] = '0;
    end
    for (int unsigned g = 0; g < NCYC; g++) begin
      if (cnt == CW'(g)) begin
        for (int unsigned l = 0; l < LANES; l++) begin
          grp_in[l] = work[32*(g*LANES + l) +: 32];
        end
      end
    end
    for (int unsigned l = 0; l < LANES; l++) begin
      grp_out[l] = col_mix(grp_in[l], sel_fwd);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      work <= '0;
      res  <= '0;
    end else if (state == IDLE && in_valid) begin
      work <= in_data;
      cnt  <= '0;
    end else if (state == BUSY) begin
      for (int unsigned c = 0; c < 4; c++) begin
        if (CW'(c / LANES) == cnt) begin
          res[32*c +: 32] <= grp_out[c % LANES];
        end
      end
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign out_data = res;

endmodule
